// File: rtl/lcd_pixel_feeder.sv
// Pixel FIFO between a frame source and an LCD panel. Timing-generator requests pop pixels,
// and the popped data leaves one cycle later, registered together with the delayed syncs.
module lcd_pixel_feeder #(
  parameter int DEPTH    = 16,
  parameter int H_ACTIVE = 480,
  parameter int V_ACTIVE = 272
) (
  input  logic                     PixelClk,
  input  logic                     RST,
  input  logic [15:0]              S_DATA,
  input  logic                     S_SOF,
  input  logic                     S_VALID,
  output logic                     S_READY,
  input  logic                     DE_IN,
  input  logic                     HSYNC_IN,
  input  logic                     VSYNC_IN,
  output logic                     LCD_DE,
  output logic                     LCD_HSYNC,
  output logic                     LCD_VSYNC,
  output logic [4:0]               LCD_R,
  output logic [5:0]               LCD_G,
  output logic [4:0]               LCD_B,
  output logic [$clog2(DEPTH):0]   FIFO_LEVEL,
  input  logic                     CLR_FLAGS,
  output logic                     UNDERFLOW,
  output logic                     SYNC_ERR
);

  localparam int AW    = $clog2(DEPTH);
  localparam int TOTAL = H_ACTIVE * V_ACTIVE;
  localparam int CW    = $clog2(TOTAL) + 1;

  typedef enum logic [1:0] {
    RESYNC = 2'd0,
    ARMED  = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t         r_state;
  logic [16:0]    r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_level;
  logic [CW-1:0]  r_count;
  logic           r_vs_seen;
  logic           r_lcd_de;
  logic           r_lcd_hsync;
  logic           r_lcd_vsync;
  logic [15:0]    r_pix;
  logic           r_underflow;
  logic           r_sync_err;

  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic           w_req;
  logic           w_pop;
  logic [16:0]    w_head;
  logic           w_bad;
  logic [CW-1:0]  w_count_inc;
  logic           w_frame_done;
  logic           w_under;

  assign w_full       = (r_level == (AW + 1)'(DEPTH));
  assign w_empty      = (r_level == '0);
  assign S_READY      = !RST && ((r_state == RESYNC) || !w_full);
  // While resyncing, only a start-of-frame word is worth keeping.
  assign w_push       = S_VALID && S_READY && ((r_state != RESYNC) || S_SOF);
  assign w_req        = DE_IN && ((r_state == STREAM) || ((r_state == ARMED) && r_vs_seen));
  assign w_pop        = w_req && !w_empty;
  assign w_head       = r_mem[r_rd_ptr];
  assign w_bad        = w_pop && ((r_count == '0) ? !w_head[16] : w_head[16]);
  assign w_count_inc  = r_count + CW'(1);
  assign w_frame_done = w_req && !w_bad && (w_count_inc == CW'(TOTAL));
  assign w_under      = w_req && w_empty;

  always_ff @(posedge PixelClk) begin
    if (w_push) r_mem[r_wr_ptr] <= {S_SOF, S_DATA};
  end

  always_ff @(posedge PixelClk) begin
    if (RST) begin
      r_state     <= RESYNC;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_count     <= '0;
      r_vs_seen   <= 1'b0;
      r_lcd_de    <= 1'b0;
      r_lcd_hsync <= 1'b1;
      r_lcd_vsync <= 1'b1;
      r_pix       <= '0;
      r_underflow <= 1'b0;
      r_sync_err  <= 1'b0;
    end else begin
      r_lcd_de    <= DE_IN;
      r_lcd_hsync <= HSYNC_IN;
      r_lcd_vsync <= VSYNC_IN;
      r_pix       <= (w_pop && !w_bad) ? w_head[15:0] : 16'h0000;

      // A misplaced SOF throws away everything queued, including a word arriving this cycle.
      if (w_bad) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        r_level <= r_level + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
      end

      if (w_under)        r_underflow <= 1'b1;
      else if (CLR_FLAGS) r_underflow <= 1'b0;
      if (w_bad)          r_sync_err  <= 1'b1;
      else if (CLR_FLAGS) r_sync_err  <= 1'b0;

      case (r_state)
        RESYNC: begin
          r_count   <= '0;
          r_vs_seen <= 1'b0;
          if (w_push) r_state <= ARMED;
        end
        ARMED: begin
          // r_lcd_vsync holds last cycle's VSYNC_IN, so this is the 1->0 edge.
          if (r_lcd_vsync && !VSYNC_IN) r_vs_seen <= 1'b1;
        end
        default: ;
      endcase

      if (w_req) begin
        if (w_bad) begin
          r_count <= '0;
          r_state <= RESYNC;
        end else if (w_frame_done) begin
          r_count   <= '0;
          r_vs_seen <= 1'b0;
          r_state   <= ARMED;
        end else begin
          r_count   <= w_count_inc;
          r_vs_seen <= 1'b0;
          r_state   <= STREAM;
        end
      end
    end
  end

  assign LCD_DE     = r_lcd_de;
  assign LCD_HSYNC  = r_lcd_hsync;
  assign LCD_VSYNC  = r_lcd_vsync;
  assign LCD_R      = r_pix[15:11];
  assign LCD_G      = r_pix[10:5];
  assign LCD_B      = r_pix[4:0];
  assign FIFO_LEVEL = r_level;
  assign UNDERFLOW  = r_underflow;
  assign SYNC_ERR   = r_sync_err;

endmodule

// File: tb/tb_lcd_pixel_feeder.sv
// Directed bench for lcd_pixel_feeder on a tiny 4x2 frame with an 8-entry FIFO.
module tb_lcd_pixel_feeder;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_data;
  logic        s_sof;
  logic        s_valid;
  logic        s_ready;
  logic        de_in;
  logic        hsync_in;
  logic        vsync_in;
  logic        lcd_de;
  logic        lcd_hsync;
  logic        lcd_vsync;
  logic [4:0]  lcd_r;
  logic [5:0]  lcd_g;
  logic [4:0]  lcd_b;
  logic [3:0]  fifo_level;
  logic        clr_flags;
  logic        underflow;
  logic        sync_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lcd_pixel_feeder #(.DEPTH(8), .H_ACTIVE(4), .V_ACTIVE(2)) dut (
    .PixelClk(clk), .RST(rst), .S_DATA(s_data), .S_SOF(s_sof), .S_VALID(s_valid), .S_READY(s_ready),
    .DE_IN(de_in), .HSYNC_IN(hsync_in), .VSYNC_IN(vsync_in), .LCD_DE(lcd_de), .LCD_HSYNC(lcd_hsync),
    .LCD_VSYNC(lcd_vsync), .LCD_R(lcd_r), .LCD_G(lcd_g), .LCD_B(lcd_b), .FIFO_LEVEL(fifo_level),
    .CLR_FLAGS(clr_flags), .UNDERFLOW(underflow), .SYNC_ERR(sync_err)
  );

  wire [15:0] w_pix = {lcd_r, lcd_g, lcd_b};
  wire [1:0]  w_state = 2'(dut.r_state);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic vsync_pulse;
    vsync_in = 1'b0;
    tick();
    vsync_in = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (lcd_de !== 1'b0) begin n_errors++; $display("FAIL rst_de actual=%0b required=0", lcd_de); end
    n_checks++; if ({lcd_hsync, lcd_vsync} !== 2'b11) begin n_errors++; $display("FAIL rst_syncs actual=%b required=11", {lcd_hsync, lcd_vsync}); end
    n_checks++; if (w_pix !== 16'h0000) begin n_errors++; $display("FAIL rst_pix actual=%h required=0000", w_pix); end
    n_checks++; if (s_ready !== 1'b0) begin n_errors++; $display("FAIL rst_ready actual=%0b required=0", s_ready); end
    n_checks++; if ({underflow, sync_err, fifo_level} !== 6'd0) begin n_errors++; $display("FAIL rst_flags_level actual=%b required=000000", {underflow, sync_err, fifo_level}); end
    rst = 1'b0;
    #1;
    n_checks++; if (w_state !== 2'd0 || s_ready !== 1'b1) begin n_errors++; $display("FAIL rst_resync state=%0d ready=%0b required state=0 ready=1", w_state, s_ready); end
    $display("test_reset done");
  endtask

  task automatic test_fill;
    for (int i = 1; i <= 8; i++) begin
      s_valid = 1'b1; s_data = 16'(i); s_sof = (i == 1);
      tick();
    end
    s_valid = 1'b0; s_sof = 1'b0;
    #1;
    n_checks++; if (fifo_level !== 4'd8) begin n_errors++; $display("FAIL fill_level actual=%0d required=8", fifo_level); end
    n_checks++; if (s_ready !== 1'b0) begin n_errors++; $display("FAIL fill_ready actual=%0b required=0", s_ready); end
    n_checks++; if (w_state !== 2'd1) begin n_errors++; $display("FAIL fill_state actual=%0d required=1", w_state); end
    $display("test_fill done level=%0d", fifo_level);
  endtask

  task automatic test_frame;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    tick();
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    n_checks++; if ({lcd_hsync, lcd_vsync} !== 2'b00) begin n_errors++; $display("FAIL frame_syncs actual=%b required=00", {lcd_hsync, lcd_vsync}); end
    for (int ln = 0; ln < 2; ln++) begin
      if (ln == 1) vsync_pulse();
      for (int p = 1; p <= 4; p++) begin
        de_in = 1'b1;
        tick();
        n_checks++;
        if (lcd_de !== 1'b1 || w_pix !== 16'(ln * 4 + p)) begin
          n_errors++; $display("FAIL frame_px de=%0b actual=%h required=%h", lcd_de, w_pix, 16'(ln * 4 + p));
        end
        $display("frame pixel %0d out=%h", ln * 4 + p, w_pix);
      end
      de_in = 1'b0;
      tick();
      n_checks++; if (lcd_de !== 1'b0 || w_pix !== 16'h0000) begin n_errors++; $display("FAIL frame_blank de=%0b pix=%h required de=0 pix=0000", lcd_de, w_pix); end
    end
    n_checks++; if (w_state !== 2'd1 || fifo_level !== 4'd0) begin n_errors++; $display("FAIL frame_end state=%0d level=%0d required state=1 level=0", w_state, fifo_level); end
  endtask

  task automatic test_underflow;
    s_valid = 1'b1; s_data = 16'h1234; s_sof = 1'b1;
    tick();
    s_valid = 1'b0; s_sof = 1'b0;
    vsync_pulse();
    de_in = 1'b1;
    tick();
    n_checks++; if (w_pix !== 16'h1234 || w_state !== 2'd2) begin n_errors++; $display("FAIL uf_first pix=%h state=%0d required pix=1234 state=2", w_pix, w_state); end
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    de_in = 1'b0;
    n_checks++; if (lcd_de !== 1'b1 || w_pix !== 16'h0000) begin n_errors++; $display("FAIL uf_black de=%0b pix=%h required de=1 pix=0000", lcd_de, w_pix); end
    n_checks++; if (underflow !== 1'b1) begin n_errors++; $display("FAIL uf_set_wins actual=%0b required=1", underflow); end
    tick();
    n_checks++; if (underflow !== 1'b1) begin n_errors++; $display("FAIL uf_sticky actual=%0b required=1", underflow); end
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    n_checks++; if (underflow !== 1'b0) begin n_errors++; $display("FAIL uf_clear actual=%0b required=0", underflow); end
    $display("test_underflow done");
  endtask

  task automatic test_sync_err;
    s_valid = 1'b1; s_data = 16'h00AA; s_sof = 1'b1;
    tick();
    s_valid = 1'b0; s_sof = 1'b0;
    de_in = 1'b1;
    tick();
    de_in = 1'b0;
    n_checks++; if (sync_err !== 1'b1) begin n_errors++; $display("FAIL se_flag actual=%0b required=1", sync_err); end
    n_checks++; if (fifo_level !== 4'd0 || w_state !== 2'd0) begin n_errors++; $display("FAIL se_flush level=%0d state=%0d required level=0 state=0", fifo_level, w_state); end
    n_checks++; if (lcd_de !== 1'b1 || w_pix !== 16'h0000) begin n_errors++; $display("FAIL se_black de=%0b pix=%h required de=1 pix=0000", lcd_de, w_pix); end
    n_checks++; if (underflow !== 1'b0) begin n_errors++; $display("FAIL se_no_uf actual=%0b required=0", underflow); end
    $display("test_sync_err done");
  endtask

  task automatic test_resync_discard;
    for (int i = 1; i <= 3; i++) begin
      s_valid = 1'b1; s_data = 16'(i * 16'h0101); s_sof = 1'b0;
      #1;
      n_checks++; if (s_ready !== 1'b1) begin n_errors++; $display("FAIL rs_ready actual=%0b required=1", s_ready); end
      tick();
    end
    n_checks++; if (fifo_level !== 4'd0 || w_state !== 2'd0) begin n_errors++; $display("FAIL rs_discard level=%0d state=%0d required level=0 state=0", fifo_level, w_state); end
    s_data = 16'h0F0F; s_sof = 1'b1;
    tick();
    s_valid = 1'b0; s_sof = 1'b0;
    n_checks++; if (fifo_level !== 4'd1 || w_state !== 2'd1) begin n_errors++; $display("FAIL rs_sof level=%0d state=%0d required level=1 state=1", fifo_level, w_state); end
    $display("test_resync_discard done level=%0d", fifo_level);
  endtask

  task automatic test_back_to_back_reset;
    s_valid = 1'b1; s_data = 16'h0002; s_sof = 1'b0;
    tick();
    s_valid = 1'b0;
    vsync_pulse();
    s_valid = 1'b1; s_data = 16'h0003; de_in = 1'b1;
    tick();
    s_valid = 1'b0;
    n_checks++; if (w_pix !== 16'h0F0F || fifo_level !== 4'd2 || w_state !== 2'd2) begin
      n_errors++; $display("FAIL b2b pix=%h level=%0d state=%0d required pix=0f0f level=2 state=2", w_pix, fifo_level, w_state);
    end
    rst = 1'b1;
    tick();
    n_checks++; if (lcd_de !== 1'b0 || w_pix !== 16'h0000 || {lcd_hsync, lcd_vsync} !== 2'b11) begin
      n_errors++; $display("FAIL mid_rst_out de=%0b pix=%h syncs=%b required de=0 pix=0000 syncs=11", lcd_de, w_pix, {lcd_hsync, lcd_vsync});
    end
    n_checks++; if (fifo_level !== 4'd0 || s_ready !== 1'b0 || sync_err !== 1'b0 || w_state !== 2'd0) begin
      n_errors++; $display("FAIL mid_rst_state level=%0d ready=%0b serr=%0b state=%0d required 0 0 0 0", fifo_level, s_ready, sync_err, w_state);
    end
    rst = 1'b0; de_in = 1'b0;
    tick();
    $display("test_back_to_back_reset done");
  endtask

  initial begin
    rst = 1'b1; s_data = '0; s_sof = 1'b0; s_valid = 1'b0; de_in = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1; clr_flags = 1'b0;
    test_reset();
    test_fill();
    test_frame();
    test_underflow();
    test_sync_err();
    test_resync_discard();
    test_back_to_back_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
